// File: rtl/pwm_demod.sv
// PWM byte receiver: classifies each bit period by its high time against 5*b,
// assembles LSB-first bytes and writes them to a downstream FIFO.
module pwm_demod #(
    parameter int BITS_PER_DC = 22,
    parameter int BIT_POS_MAX = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   PWM_IN,
    input  logic [BITS_PER_DC-1:0] base_counter,
    output logic [7:0]             fifo_dout,
    output logic                   fifo_WE,
    input  logic                   fifo_full,
    output logic                   rx_active,
    output logic                   frame_err,
    output logic                   ovf_err
);

    localparam int CW = BITS_PER_DC + 5;
    localparam int PW = (BIT_POS_MAX > 1) ? $clog2(BIT_POS_MAX) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HIGH  = 2'd1;
    localparam logic [1:0] LOW   = 2'd2;
    localparam logic [1:0] STUCK = 2'd3;

    localparam logic [PW-1:0] LAST_POS = PW'(BIT_POS_MAX - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   s;
    logic                   rise;
    logic                   fall;

    logic [CW-1:0] b_ext;
    logic [CW-1:0] thr;
    logic [CW-1:0] per;
    logic [CW-1:0] tmo;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] bit_pos_q, bit_pos_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CW-1:0] lo_cnt_q, lo_cnt_d;
    logic [7:0]    dout_q, dout_d;
    logic          we_q, we_d;
    logic          ferr_q, ferr_d;
    logic          ovf_q, ovf_d;

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Synchronizer and edge flop preset high so a line already low at reset
    // only produces a fall, which IDLE ignores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            s_d_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PWM_IN};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    assign b_ext = {5'b0, base_counter};
    assign thr   = (b_ext << 2) + b_ext;
    assign per   = (b_ext << 3) + (b_ext << 1);
    assign tmo   = per << 1;

    always_comb begin
        state_d   = state_q;
        bit_pos_d = bit_pos_q;
        shreg_d   = shreg_q;
        hi_cnt_d  = hi_cnt_q;
        lo_cnt_d  = lo_cnt_q;
        dout_d    = dout_q;
        we_d      = 1'b0;
        ferr_d    = 1'b0;
        ovf_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (base_counter != '0 && rise) begin
                    hi_cnt_d  = CNT_ONE;
                    bit_pos_d = '0;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (hi_cnt_q > per) begin
                    ferr_d    = 1'b1;
                    bit_pos_d = '0;
                    state_d   = STUCK;
                end else if (fall) begin
                    shreg_d[bit_pos_q] = (hi_cnt_q >= thr);
                    if (bit_pos_q == LAST_POS) begin
                        if (!fifo_full) begin
                            we_d   = 1'b1;
                            dout_d = shreg_d;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        bit_pos_d = '0;
                    end else begin
                        bit_pos_d = bit_pos_q + PW'(1);
                    end
                    lo_cnt_d = CNT_ONE;
                    state_d  = LOW;
                end else if (s) begin
                    hi_cnt_d = satInc(hi_cnt_q);
                end
            end
            LOW: begin
                // A rise here is the next bit, possibly bit 0 of the next byte.
                if (rise) begin
                    hi_cnt_d = CNT_ONE;
                    state_d  = HIGH;
                end else if (lo_cnt_q > tmo) begin
                    ferr_d    = (bit_pos_q != '0);
                    bit_pos_d = '0;
                    state_d   = IDLE;
                end else if (!s) begin
                    lo_cnt_d = satInc(lo_cnt_q);
                end
            end
            STUCK: begin
                if (fall) begin
                    lo_cnt_d  = CNT_ONE;
                    bit_pos_d = '0;
                    state_d   = LOW;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_pos_q <= '0;
            shreg_q   <= '0;
            hi_cnt_q  <= '0;
            lo_cnt_q  <= '0;
            dout_q    <= '0;
            we_q      <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_pos_q <= bit_pos_d;
            shreg_q   <= shreg_d;
            hi_cnt_q  <= hi_cnt_d;
            lo_cnt_q  <= lo_cnt_d;
            dout_q    <= dout_d;
            we_q      <= we_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign fifo_dout = dout_q;
    assign fifo_WE   = we_q;
    assign frame_err = ferr_q;
    assign ovf_err   = ovf_q;
    assign rx_active = (state_q == HIGH) || (state_q == LOW);

endmodule

// File: tb/tb_pwm_demod.sv
// Scoreboard bench for pwm_demod: stimulus pushes expected writes/errors with
// their cycle numbers, a negedge monitor pops and compares as they appear.
module tb_pwm_demod;

    localparam int SYNC = 2;
    localparam int PERIOD = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PWM_IN = 1'b0;
    logic        fifo_full = 1'b0;
    logic [21:0] base_counter = 22'd4;
    logic [7:0]  fifo_dout;
    logic        fifo_WE;
    logic        rx_active;
    logic        frame_err;
    logic        ovf_err;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t expWrQ[$];
    int  expFrameQ[$];
    int  expOvfQ[$];
    int  cyc = 0;
    int  checkCnt = 0;
    int  passCnt = 0;
    int  lastFallCyc = 0;
    bit  prevFrame = 1'b0;
    bit  prevOvf = 1'b0;

    pwm_demod #(
        .BITS_PER_DC(22),
        .BIT_POS_MAX(8),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .PWM_IN(PWM_IN),
        .base_counter(base_counter),
        .fifo_dout(fifo_dout),
        .fifo_WE(fifo_WE),
        .fifo_full(fifo_full),
        .rx_active(rx_active),
        .frame_err(frame_err),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCnt++;
        if (actual == expected) passCnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic reportUnexpected(input string name, input int actual);
        checkCnt++;
        $display("[TB] FAIL %s: got event at cycle %0d, expected none", name, actual);
    endtask

    // One bit period starting at a negedge; kind 1/2 records the expected
    // write/overflow at the cycle the falling edge reaches the FSM output.
    task automatic applyStimulus(input int hi, input int kind, input logic [7:0] d);
        PWM_IN = 1'b1;
        repeat (hi) @(negedge clk);
        PWM_IN = 1'b0;
        lastFallCyc = cyc;
        if (kind == 1) expWrQ.push_back('{data: d, cyc: cyc + 1 + SYNC});
        else if (kind == 2) expOvfQ.push_back(cyc + 1 + SYNC);
        repeat (PERIOD - hi) @(negedge clk);
    endtask

    task automatic sendPulses(input int hiW[8], input logic [7:0] d, input bit ovf);
        for (int i = 0; i < 8; i++)
            applyStimulus(hiW[i], (i == 7) ? (ovf ? 2 : 1) : 0, d);
    endtask

    task automatic sendByte(input logic [7:0] d, input bit ovf);
        int w[8];
        for (int i = 0; i < 8; i++) w[i] = d[i] ? 31 : 7;
        sendPulses(w, d, ovf);
    endtask

    task automatic holdLow(input int n);
        PWM_IN = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " fifo_WE"}, fifo_WE, 0);
        checkOutput({tag, " fifo_dout"}, fifo_dout, 0);
        checkOutput({tag, " rx_active"}, rx_active, 0);
        checkOutput({tag, " frame_err"}, frame_err, 0);
        checkOutput({tag, " ovf_err"}, ovf_err, 0);
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        int  c;
        if (fifo_WE) begin
            if (expWrQ.size() == 0) reportUnexpected("fifo_WE", cyc);
            else begin
                e = expWrQ.pop_front();
                checkOutput("fifo_dout", fifo_dout, e.data);
                checkOutput("fifo_WE cycle", cyc, e.cyc);
            end
        end
        if (frame_err) begin
            if (expFrameQ.size() == 0) reportUnexpected("frame_err", cyc);
            else begin
                c = expFrameQ.pop_front();
                checkOutput("frame_err cycle", cyc, c);
            end
        end
        if (ovf_err) begin
            if (expOvfQ.size() == 0) reportUnexpected("ovf_err", cyc);
            else begin
                c = expOvfQ.pop_front();
                checkOutput("ovf_err cycle", cyc, c);
            end
        end
        if (fifo_WE && ovf_err) reportUnexpected("fifo_WE with ovf_err", cyc);
        if (prevFrame) checkOutput("frame_err width", frame_err, 0);
        if (prevOvf) checkOutput("ovf_err width", ovf_err, 0);
        prevFrame <= frame_err;
        prevOvf   <= ovf_err;
    end

    initial begin
        int thrW[8];

        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        holdLow(5);

        $display("[TB] single byte 0xA5");
        sendByte(8'hA5, 1'b0);
        checkOutput("rx_active after byte", rx_active, 1);
        repeat (lastFallCyc + 83 - cyc) @(negedge clk);
        checkOutput("rx_active at lo_cnt 81", rx_active, 1);
        @(negedge clk);
        checkOutput("rx_active after timeout", rx_active, 0);
        holdLow(20);

        $display("[TB] continuous stream");
        sendByte(8'h00, 1'b0);
        sendByte(8'hFF, 1'b0);
        sendByte(8'h3C, 1'b0);
        holdLow(120);

        $display("[TB] threshold boundary");
        for (int i = 0; i < 8; i++) thrW[i] = (i % 2 == 0) ? 20 : 19;
        sendPulses(thrW, 8'h55, 1'b0);
        holdLow(120);

        $display("[TB] overflow");
        fifo_full = 1'b1;
        sendByte(8'h12, 1'b1);
        fifo_full = 1'b0;
        sendByte(8'h34, 1'b0);
        holdLow(120);

        $display("[TB] truncated byte");
        applyStimulus(31, 0, 8'h00);
        applyStimulus(7, 0, 8'h00);
        applyStimulus(31, 0, 8'h00);
        expFrameQ.push_back(lastFallCyc + SYNC + 82);
        holdLow(120);
        checkOutput("rx_active after truncation", rx_active, 0);

        $display("[TB] stuck high");
        PWM_IN = 1'b1;
        expFrameQ.push_back(cyc + SYNC + 42);
        repeat (50) @(negedge clk);
        holdLow(10);
        sendByte(8'h5A, 1'b0);
        holdLow(120);

        $display("[TB] reset mid-byte");
        for (int i = 0; i < 4; i++) applyStimulus(7, 0, 8'h00);
        checkOutput("rx_active before reset", rx_active, 1);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("mid reset");
        @(negedge clk);
        reset = 1'b0;
        holdLow(20);
        sendByte(8'h81, 1'b0);
        holdLow(120);

        checkOutput("pending writes", expWrQ.size(), 0);
        checkOutput("pending frame errors", expFrameQ.size(), 0);
        checkOutput("pending overflows", expOvfQ.size(), 0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
